// File: rtl/phy_lane_arbiter.sv
// Round-robin arbiter sharing one PHY transmit channel among four lane requesters; optional lane 0 priority via PHY_ARB_LANE0_PRIO_EN.
// Latency: grant 1 cycle after req in IDLE; word registered 1 cycle after the transfer cycle.
// Backpressure: ready_in low with valid_out high stalls transfers, holding grant and burst count.
module phy_lane_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int WIDTH     = 9
) (
    input  logic             clk4f,
    input  logic             reset_L,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] paralelo0,
    input  logic [WIDTH-1:0] paralelo1,
    input  logic [WIDTH-1:0] paralelo2,
    input  logic [WIDTH-1:0] paralelo3,
    input  logic             ready_in,
    output logic [3:0]       grant,
    output logic [WIDTH-1:0] data_out,
    output logic [1:0]       lane_out,
    output logic             valid_out
);

    typedef enum logic {S_IDLE, S_OWN} state_t;

    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

    state_t           state_q;
    logic [1:0]       owner_q;
    logic [1:0]       rr_ptr_q;
    logic [3:0]       burst_cnt_q;
    logic [3:0]       grant_q;
    logic [WIDTH-1:0] data_q;
    logic [1:0]       lane_q;
    logic             valid_q;

    logic [WIDTH-1:0] lane_word [4];
    logic [3:0]       owner_mask;
    logic             load_en;
    logic             xfer;
    logic             burst_end;
    logic             release_own;
    logic [3:0]       others;
    logic [3:0]       scan_req_d;
    logic [1:0]       scan_start_d;
    logic             pick_vld_d;
    logic [1:0]       owner_d;

    // First set bit of r, scanning start, start+1, ... modulo 4.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
        logic [1:0] idx;
        logic       found;
        rr_pick = start;
        found   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = start + 2'(i);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    always_comb begin
        lane_word[0] = paralelo0;
        lane_word[1] = paralelo1;
        lane_word[2] = paralelo2;
        lane_word[3] = paralelo3;
    end

    assign owner_mask = 4'b0001 << owner_q;
    assign load_en    = !valid_q || ready_in;
    assign xfer       = (state_q == S_OWN) && req[owner_q] && load_en;

`ifdef PHY_ARB_LANE0_PRIO_EN
    assign burst_end  = xfer && (burst_cnt_q == BURST_LAST) && (owner_q != 2'd0);
`else
    assign burst_end  = xfer && (burst_cnt_q == BURST_LAST);
`endif

    assign release_own = (state_q == S_OWN) && (!req[owner_q] || burst_end);
    assign others      = req & ~owner_mask;

    // A forced rotation skips the owner unless nobody else is waiting.
    always_comb begin
        scan_req_d   = req;
        scan_start_d = rr_ptr_q;
        if (state_q == S_OWN) begin
            scan_start_d = owner_q + 2'd1;
            if (burst_end && (others != 4'b0000)) begin
                scan_req_d = others;
            end
        end
        pick_vld_d = |scan_req_d;
`ifdef PHY_ARB_LANE0_PRIO_EN
        owner_d = scan_req_d[0] ? 2'd0 : rr_pick(scan_req_d, scan_start_d);
`else
        owner_d = rr_pick(scan_req_d, scan_start_d);
`endif
    end

    always_ff @(posedge clk4f or negedge reset_L) begin
        if (!reset_L) begin
            state_q     <= S_IDLE;
            owner_q     <= 2'd0;
            rr_ptr_q    <= 2'd0;
            burst_cnt_q <= 4'd0;
            grant_q     <= 4'b0000;
            data_q      <= '0;
            lane_q      <= 2'd0;
            valid_q     <= 1'b0;
        end else begin
            if (xfer) begin
                data_q  <= lane_word[owner_q];
                lane_q  <= owner_q;
                valid_q <= 1'b1;
            end else if (valid_q && ready_in) begin
                valid_q <= 1'b0;
            end

            if (state_q == S_IDLE) begin
                if (pick_vld_d) begin
                    state_q     <= S_OWN;
                    owner_q     <= owner_d;
                    grant_q     <= 4'b0001 << owner_d;
                    burst_cnt_q <= 4'd0;
                end
            end else begin
                if (release_own) begin
                    rr_ptr_q    <= owner_q + 2'd1;
                    burst_cnt_q <= 4'd0;
                    if (pick_vld_d) begin
                        owner_q <= owner_d;
                        grant_q <= 4'b0001 << owner_d;
                    end else begin
                        state_q <= S_IDLE;
                        grant_q <= 4'b0000;
                    end
                end else if (xfer) begin
                    burst_cnt_q <= burst_cnt_q + 4'd1;
                end
            end
        end
    end

    assign grant     = grant_q;
    assign data_out  = data_q;
    assign lane_out  = lane_q;
    assign valid_out = valid_q;

endmodule

// File: tb/tb_phy_lane_arbiter.sv
// Directed bench for phy_lane_arbiter: cycle trace table plus reset, fairness and stall sequences.
`timescale 1ns/100ps
module tb_phy_lane_arbiter;

    logic       clk4f = 1'b0;
    logic       reset_L;
    logic [3:0] req;
    logic [8:0] par [4];
    logic       ready_in;
    logic [3:0] grant;
    logic [8:0] data_out;
    logic [1:0] lane_out;
    logic       valid_out;

    int nerr = 0;
    int nchk = 0;

    // Lane source model: each lane presents {1, lane, n} where n counts its retired words.
    logic       src_mode = 1'b0;
    logic [3:0] en = 4'b0000;
    int         cnt [4];

    phy_lane_arbiter #(.MAX_BURST(4), .WIDTH(9)) dut (
        .clk4f    (clk4f),
        .reset_L  (reset_L),
        .req      (req),
        .paralelo0(par[0]),
        .paralelo1(par[1]),
        .paralelo2(par[2]),
        .paralelo3(par[3]),
        .ready_in (ready_in),
        .grant    (grant),
        .data_out (data_out),
        .lane_out (lane_out),
        .valid_out(valid_out)
    );

    always #5 clk4f = ~clk4f;

    function automatic logic [8:0] word(input int lane, input int n);
        return {1'b1, 2'(lane), 6'(n)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_src();
        if (src_mode) begin
            req = en;
            for (int i = 0; i < 4; i++) par[i] = word(i, cnt[i]);
        end
    endtask

    task automatic tick();
        logic [3:0] ret;
        ret = grant & req & {4{(!valid_out || ready_in)}};
        @(posedge clk4f);
        #1;
        for (int i = 0; i < 4; i++) if (ret[i]) cnt[i]++;
        drive_src();
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        drive_src();
        #1;
        reset_L = 1'b1;
    endtask

    typedef struct {
        logic [3:0] req;
        logic       rdy;
        logic [3:0] g;
        logic [8:0] d;
        logic [1:0] l;
        logic       v;
    } vec_t;

    vec_t tv [19];

    initial begin
        tv[0]  = '{4'b0100, 1'b1, 4'b0100, 9'h000, 2'd0, 1'b0};
        tv[1]  = '{4'b0100, 1'b1, 4'b0100, 9'h1A5, 2'd2, 1'b1};
        tv[2]  = '{4'b0000, 1'b1, 4'b0000, 9'h1A5, 2'd2, 1'b0};
        tv[3]  = '{4'b1000, 1'b1, 4'b1000, 9'h1A5, 2'd2, 1'b0};
        tv[4]  = '{4'b1010, 1'b1, 4'b1000, 9'h05A, 2'd3, 1'b1};
        tv[5]  = '{4'b1010, 1'b1, 4'b1000, 9'h05A, 2'd3, 1'b1};
        tv[6]  = '{4'b0010, 1'b1, 4'b0010, 9'h05A, 2'd3, 1'b0};
        tv[7]  = '{4'b0010, 1'b0, 4'b0010, 9'h0C3, 2'd1, 1'b1};
        tv[8]  = '{4'b0010, 1'b0, 4'b0010, 9'h0C3, 2'd1, 1'b1};
        tv[9]  = '{4'b0010, 1'b0, 4'b0010, 9'h0C3, 2'd1, 1'b1};
        tv[10] = '{4'b0010, 1'b1, 4'b0010, 9'h0C3, 2'd1, 1'b1};
        tv[11] = '{4'b1100, 1'b1, 4'b0100, 9'h0C3, 2'd1, 1'b0};
        tv[12] = '{4'b1100, 1'b1, 4'b0100, 9'h1A5, 2'd2, 1'b1};
        tv[13] = '{4'b1100, 1'b1, 4'b0100, 9'h1A5, 2'd2, 1'b1};
        tv[14] = '{4'b1100, 1'b1, 4'b0100, 9'h1A5, 2'd2, 1'b1};
        tv[15] = '{4'b1100, 1'b1, 4'b1000, 9'h1A5, 2'd2, 1'b1};
        tv[16] = '{4'b1100, 1'b1, 4'b1000, 9'h05A, 2'd3, 1'b1};
        tv[17] = '{4'b0000, 1'b1, 4'b0000, 9'h05A, 2'd3, 1'b0};
        tv[18] = '{4'b0110, 1'b1, 4'b0010, 9'h05A, 2'd3, 1'b0};

        for (int i = 0; i < 4; i++) cnt[i] = 0;
        reset_L  = 1'b0;
        req      = 4'b0000;
        ready_in = 1'b1;
        par[0]   = 9'h101;
        par[1]   = 9'h0C3;
        par[2]   = 9'h1A5;
        par[3]   = 9'h05A;

        #3;
        chk("reset grant", 32'(grant), 32'h0);
        chk("reset data", 32'(data_out), 32'h0);
        chk("reset lane", 32'(lane_out), 32'h0);
        chk("reset valid", 32'(valid_out), 32'h0);
        #4;
        reset_L = 1'b1;

        // Cycle-by-cycle trace with fixed lane words.
        for (int i = 0; i < 19; i++) begin
            req      = tv[i].req;
            ready_in = tv[i].rdy;
            tick();
            chk($sformatf("v%0d grant", i), 32'(grant), 32'(tv[i].g));
            chk($sformatf("v%0d data", i), 32'(data_out), 32'(tv[i].d));
            chk($sformatf("v%0d lane", i), 32'(lane_out), 32'(tv[i].l));
            chk($sformatf("v%0d valid", i), 32'(valid_out), 32'(tv[i].v));
        end

        // Reset asserted mid-burst on lane 2.
        src_mode = 1'b1;
        ready_in = 1'b1;
        en       = 4'b0100;
        do_reset();
        tick();
        tick();
        tick();
        chk("pre-reset valid", 32'(valid_out), 32'h1);
        reset_L = 1'b0;
        #0.5;
        chk("midreset grant", 32'(grant), 32'h0);
        chk("midreset valid", 32'(valid_out), 32'h0);
        chk("midreset data", 32'(data_out), 32'h0);
        #0.5;
        en = 4'b0001;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        drive_src();
        reset_L = 1'b1;
        tick();
        chk("post-reset grant", 32'(grant), 32'h1);
        chk("post-reset valid", 32'(valid_out), 32'h0);

        // All lanes requesting continuously.
        en = 4'b1111;
        do_reset();
        tick();
        chk("all-req first grant", 32'(grant), 32'h1);
        chk("all-req first valid", 32'(valid_out), 32'h0);
        for (int k = 0; k < 20; k++) begin
            int el;
            int en_n;
            tick();
`ifdef PHY_ARB_LANE0_PRIO_EN
            el   = 0;
            en_n = k;
`else
            el   = (k / 4) % 4;
            en_n = (k / 16) * 4 + (k % 4);
`endif
            chk($sformatf("rr%0d lane", k), 32'(lane_out), 32'(el));
            chk($sformatf("rr%0d data", k), 32'(data_out), 32'(word(el, en_n)));
            chk($sformatf("rr%0d valid", k), 32'(valid_out), 32'h1);
        end
`ifdef PHY_ARB_LANE0_PRIO_EN
        en = 4'b1110;
        drive_src();
        tick();
        chk("prio lane1 after drop", 32'(grant), 32'h2);
`endif

        // Backpressure on lane 1 with lane 3 waiting.
        en = 4'b1010;
        ready_in = 1'b1;
        do_reset();
        tick();
        chk("bp grant", 32'(grant), 32'h2);
        tick();
        chk("bp first word", 32'(data_out), 32'(word(1, 0)));
        ready_in = 1'b0;
        for (int s = 0; s < 5; s++) begin
            tick();
            chk($sformatf("bp stall%0d data", s), 32'(data_out), 32'(word(1, 0)));
            chk($sformatf("bp stall%0d valid", s), 32'(valid_out), 32'h1);
            chk($sformatf("bp stall%0d grant", s), 32'(grant), 32'h2);
        end
        ready_in = 1'b1;
        for (int s = 1; s < 4; s++) begin
            tick();
            chk($sformatf("bp resume%0d data", s), 32'(data_out), 32'(word(1, s)));
            chk($sformatf("bp resume%0d valid", s), 32'(valid_out), 32'h1);
        end
        tick();
        chk("bp rotate data", 32'(data_out), 32'(word(3, 0)));
        chk("bp rotate lane", 32'(lane_out), 32'h3);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
